lab3_serial_borrow_sub: RTL and testbench



---
 rtl/lab3_serial_borrow_sub_if.sv | 26 ++
 rtl/lab3_serial_borrow_sub.sv | 151 +++++++++++++++
 tb/tb_lab3_serial_borrow_sub.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_serial_borrow_sub_if.sv
// Operand/result bundle for the digit-serial borrow subtractor.
interface lab3_serial_borrow_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Z;
  logic             Neg;
  logic             V;

  modport master (
    output start, X, Y, Bin,
    input  busy, done, Diff, Bout, Z, Neg, V
  );

  modport slave (
    input  start, X, Y, Bin,
    output busy, done, Diff, Bout, Z, Neg, V
  );
endinterface

// File: rtl/lab3_serial_borrow_sub.sv
// Digit-serial subtractor: computes X - Y - Bin, DIGIT bits per clock, LSD first,
// with Diff/Bout/Z/Neg/V published on the final digit edge.
module lab3_serial_borrow_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  lab3_serial_borrow_sub_if.slave bus
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(N + 1);

  generate
    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("lab3_serial_borrow_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               step;
  logic               last;

  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   acc_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               z_q;
  logic               neg_q;
  logic               v_q;
  logic               busy_q;
  logic               done_q;

  logic [DIGIT-1:0]   slice_diff;
  logic               slice_bout;
  logic [WIDTH-1:0]   acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last = (cnt_q == CNT_W'(N - 1));

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ripple-borrow across one digit slice of the operand shift registers
  always_comb begin : slice_sub
    logic b;
    b          = borrow_q;
    slice_diff = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      slice_diff[i] = x_q[i] ^ y_q[i] ^ b;
      b             = (~x_q[i] & y_q[i]) | (~(x_q[i] ^ y_q[i]) & b);
    end
    slice_bout = b;
  end

  // New digit enters at the top; after N steps the LSD has reached bit 0
  assign acc_nxt = (acc_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      z_q      <= 1'b1;
      neg_q    <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (load) begin
        x_q      <= bus.X;
        y_q      <= bus.Y;
        borrow_q <= bus.Bin;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (step) begin
        x_q      <= x_q >> DIGIT;
        y_q      <= y_q >> DIGIT;
        borrow_q <= slice_bout;
        acc_q    <= acc_nxt;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last) begin
          // Operand MSBs sit at bit DIGIT-1 once the top slice has shifted down
          diff_q <= acc_nxt;
          bout_q <= slice_bout;
          z_q    <= (acc_nxt == '0);
          neg_q  <= acc_nxt[WIDTH-1];
          v_q    <= (x_q[DIGIT-1] ^ y_q[DIGIT-1]) & (x_q[DIGIT-1] ^ acc_nxt[WIDTH-1]);
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.Z    = z_q;
  assign bus.Neg  = neg_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_lab3_serial_borrow_sub.sv
// Bench for lab3_serial_borrow_sub: three configurations, table vectors,
// multi-cycle corner sequences and a 16-bit random sweep against a model.
module tb_lab3_serial_borrow_sub;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        z;
    logic        neg;
    logic        v;
  } exp_t;

  typedef struct {
    int          d;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   done_cnt [3];
  exp_t sb [3][$];

  lab3_serial_borrow_sub_if #(.WIDTH(8))  b0 ();
  lab3_serial_borrow_sub_if #(.WIDTH(8))  b1 ();
  lab3_serial_borrow_sub_if #(.WIDTH(16)) b2 ();

  lab3_serial_borrow_sub #(.WIDTH(8),  .DIGIT(1)) u_w8_d1  (.clk(clk), .rst_n(rst_n), .bus(b0));
  lab3_serial_borrow_sub #(.WIDTH(8),  .DIGIT(4)) u_w8_d4  (.clk(clk), .rst_n(rst_n), .bus(b1));
  lab3_serial_borrow_sub #(.WIDTH(16), .DIGIT(8)) u_w16_d8 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;

  function automatic int nof(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return b0.done;
      1:       return b1.done;
      default: return b2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return b0.busy;
      1:       return b1.busy;
      default: return b2.busy;
    endcase
  endfunction

  function automatic exp_t get_out(input int d);
    exp_t o;
    case (d)
      0:       o = '{diff: 16'(b0.Diff), bout: b0.Bout, z: b0.Z, neg: b0.Neg, v: b0.V};
      1:       o = '{diff: 16'(b1.Diff), bout: b1.Bout, z: b1.Z, neg: b1.Neg, v: b1.V};
      default: o = '{diff: b2.Diff,      bout: b2.Bout, z: b2.Z, neg: b2.Neg, v: b2.V};
    endcase
    return o;
  endfunction

  // Reference: plain arithmetic subtraction, flags from the masked result
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic bin);
    exp_t        e;
    logic [15:0] mask;
    logic [16:0] xe, ye, full;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    xe     = {1'b0, x & mask};
    ye     = {1'b0, y & mask};
    full   = xe - ye - 17'(bin);
    e.diff = full[15:0] & mask;
    e.bout = (xe < ye + 17'(bin));
    e.z    = (e.diff == 16'h0000);
    e.neg  = e.diff[w-1];
    e.v    = (x[w-1] ^ y[w-1]) & (x[w-1] ^ e.diff[w-1]);
    return e;
  endfunction

  function automatic vec_t mkv(input int d, input logic [15:0] x, input logic [15:0] y,
                               input logic bin, input logic [15:0] diff, input logic bout,
                               input logic z, input logic neg, input logic v);
    vec_t r;
    r.d = d; r.x = x; r.y = y; r.bin = bin;
    r.e = '{diff: diff, bout: bout, z: z, neg: neg, v: v};
    return r;
  endfunction

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, req);
    end
  endfunction

  task automatic drive(input int d, input logic st, input logic [15:0] x, input logic [15:0] y,
                       input logic bin);
    case (d)
      0: begin b0.start = st; b0.X = x[7:0]; b0.Y = y[7:0]; b0.Bin = bin; end
      1: begin b1.start = st; b1.X = x[7:0]; b1.Y = y[7:0]; b1.Bin = bin; end
      default: begin b2.start = st; b2.X = x; b2.Y = y; b2.Bin = bin; end
    endcase
  endtask

  // Present one start (caller is at a negedge); operands are scrambled afterwards
  task automatic fire(input int d, input logic [15:0] x, input logic [15:0] y, input logic bin,
                      input exp_t e);
    sb[d].push_back(e);
    drive(d, 1'b1, x, y, bin);
    @(negedge clk);
    drive(d, 1'b0, ~x, x ^ y, ~bin);
  endtask

  task automatic wait_done(input int d, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!get_done(d) && cycles < budget);
    if (!get_done(d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL d%0d_done_timeout: got no done in %0d cycles", d, budget);
    end
  endtask

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    exp_t e, o;
    for (int d = 0; d < 3; d++) begin
      if (get_done(d)) begin
        done_cnt[d]++;
        if (sb[d].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL d%0d_unexpected_done: got done=1 required done=0", d);
        end else begin
          e = sb[d].pop_front();
          o = get_out(d);
          check($sformatf("d%0d_diff", d), o.diff, e.diff);
          check($sformatf("d%0d_bout", d), 16'(o.bout), 16'(e.bout));
          check($sformatf("d%0d_z", d),    16'(o.z),    16'(e.z));
          check($sformatf("d%0d_neg", d),  16'(o.neg),  16'(e.neg));
          check($sformatf("d%0d_v", d),    16'(o.v),    16'(e.v));
        end
      end
    end
  end

  initial begin
    vec_t vecs [11];
    exp_t o;
    int   cyc;
    int   dc;
    logic [15:0] rx, ry;
    logic        rb;

    vecs[0]  = mkv(0, 16'h00C5, 16'h0056, 1'b0, 16'h006F, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mkv(0, 16'h0055, 16'h00D5, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[2]  = mkv(0, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mkv(0, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mkv(0, 16'h007F, 16'h00FF, 1'b1, 16'h007F, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mkv(1, 16'h0009, 16'h0009, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mkv(1, 16'h0033, 16'h0033, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mkv(1, 16'h00A0, 16'h0030, 1'b1, 16'h006F, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mkv(2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mkv(2, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[10] = mkv(2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 3; d++) done_cnt[d] = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      o = get_out(d);
      check($sformatf("rst_d%0d_diff", d), o.diff, 16'h0000);
      check($sformatf("rst_d%0d_flags", d), {12'h000, o.bout, o.z, o.neg, o.v}, 16'h0004);
      check($sformatf("rst_d%0d_busy_done", d), {14'h0, get_busy(d), get_done(d)}, 16'h0000);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; consecutive entries on one DUT start in its DONE cycle
    for (int i = 0; i < 11; i++) begin
      fire(vecs[i].d, vecs[i].x, vecs[i].y, vecs[i].bin, vecs[i].e);
      check($sformatf("vec%0d_busy", i), 16'(get_busy(vecs[i].d)), 16'h0001);
      wait_done(vecs[i].d, nof(vecs[i].d) + 2, cyc);
      check($sformatf("vec%0d_latency", i), 16'(cyc), 16'(nof(vecs[i].d)));
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("idle_d%0d_busy_done", d), {14'h0, get_busy(d), get_done(d)}, 16'h0000);

    // Full busy/done profile for DIGIT=1: busy for 8 cycles, then one done cycle
    fire(0, 16'h00C5, 16'h0056, 1'b0, model(8, 16'h00C5, 16'h0056, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("prof_c%0d_busy_done", k), {14'h0, b0.busy, b0.done}, 16'h0002);
      @(negedge clk);
    end
    check("prof_c9_busy_done", {14'h0, b0.busy, b0.done}, 16'h0001);
    @(negedge clk);
    check("prof_c10_busy_done", {14'h0, b0.busy, b0.done}, 16'h0000);

    // Start pulses and operand churn during RUN are ignored
    dc = done_cnt[0];
    fire(0, 16'h003C, 16'h000F, 1'b0, '{diff: 16'h002D, bout: 1'b0, z: 1'b0, neg: 1'b0, v: 1'b0});
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      @(negedge clk);
    end
    drive(0, 1'b0, 16'h00FF, 16'h0000, 1'b1);
    wait_done(0, 8, cyc);
    check("ignore_latency", 16'(cyc), 16'(4));
    repeat (12) @(negedge clk);
    check("ignore_done_count", 16'(done_cnt[0] - dc), 16'h0001);

    // Reset in RUN cycle 3 abandons the operation
    dc = done_cnt[0];
    fire(0, 16'h00AA, 16'h0011, 1'b0, model(8, 16'h00AA, 16'h0011, 1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    o = get_out(0);
    check("abort_diff", o.diff, 16'h0000);
    check("abort_flags", {12'h000, o.bout, o.z, o.neg, o.v}, 16'h0004);
    check("abort_busy_done", {14'h0, b0.busy, b0.done}, 16'h0000);
    sb[0].delete();
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 16'(done_cnt[0] - dc), 16'h0000);
    fire(0, 16'h0012, 16'h0034, 1'b1, model(8, 16'h0012, 16'h0034, 1'b1));
    wait_done(0, 10, cyc);
    check("post_abort_latency", 16'(cyc), 16'(8));
    @(negedge clk);

    // Reset wins over start on the same edge
    rst_n = 1'b0;
    drive(1, 1'b1, 16'h0005, 16'h0003, 1'b0);
    @(negedge clk);
    check("rst_prio_busy", 16'(b1.busy), 16'h0000);
    rst_n = 1'b1;
    drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("rst_prio_idle", {14'h0, b1.busy, b1.done}, 16'h0000);

    // Random sweep, WIDTH=16 DIGIT=8
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = (i % 8 == 0) ? rx : 16'($urandom);
      rb = 1'($urandom);
      fire(2, rx, ry, rb, model(16, rx, ry, rb));
      wait_done(2, 4, cyc);
    end
    @(negedge clk);
    check("sweep_queue_empty", 16'(sb[2].size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
